// File: rtl/multi_channel_press_predictor_pkg.sv
// Shared mode encoding, select-width helper and default sizing for the press predictor.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } mode_t;

  localparam int DEF_COUNT_WIDTH     = 8;
  localparam int DEF_IND_WIDTH       = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_channel_press_predictor_input_conditioner.sv
// Two-flop synchroniser, optional per-bit debounce, and rising-edge pulse.
// Rise appears two edges after raw goes high (plus debounce time when enabled); no backpressure.
module input_conditioner
  import press_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter bit DEBOUNCE        = 1'b0,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1, sync2, level, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= level;
    end
  end

  generate
    if (DEBOUNCE) begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0]    cnt [WIDTH];
      logic [WIDTH-1:0] stable;

      // Counts consecutive samples that disagree with the held level; any agreeing sample restarts it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stable <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
              stable[i] <= sync2[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end

      assign level = stable;
    end else begin : g_direct
      assign level = sync2;
    end
  endgenerate

  assign rise = level & ~prev;

endmodule

// File: rtl/multi_channel_press_predictor.sv
// Per-channel press counter with argmax prediction, hit/miss scoring and streak thermometer.
// Count and hit/miss land 3 edges after a press, predicted 1 edge later; PRESS_DECAY_EN halves all counts on overflow.
module multi_channel_press_predictor
  import press_pkg::*;
#(
  parameter int NUM_BUTTONS     = 3,
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
  parameter int IND_WIDTH       = DEF_IND_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  localparam int SEL_W          = sel_w(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   activator,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic [SEL_W-1:0]       sel,
  output logic [COUNT_WIDTH-1:0] display,
  output logic [IND_WIDTH-1:0]   indicator,
  output logic [SEL_W-1:0]       predicted,
  output logic                   hit,
  output logic                   miss
);

  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;
  localparam int STW = $clog2(IND_WIDTH + 1);

  mode_t                  state;
  logic [COUNT_WIDTH-1:0] counts [NUM_BUTTONS];
  logic [COUNT_WIDTH-1:0] nxt    [NUM_BUTTONS];
  logic [STW-1:0]         streak;
  logic                   mode_event;
  logic [NUM_BUTTONS-1:0] press;
  logic [SEL_W-1:0]       best_idx, first_idx;

  input_conditioner #(
    .WIDTH(1), .DEBOUNCE(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_activator (
    .clk(clk), .rst(rst), .raw(activator), .rise(mode_event)
  );

  input_conditioner #(
    .WIDTH(NUM_BUTTONS), .DEBOUNCE(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_buttons (
    .clk(clk), .rst(rst), .raw(buttons), .rise(press)
  );

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    logic [COUNT_WIDTH-1:0] best_cnt;
    best_idx = '0;
    best_cnt = counts[0];
    for (int i = 1; i < NUM_BUTTONS; i++) begin
      if (counts[i] > best_cnt) begin
        best_idx = SEL_W'(i);
        best_cnt = counts[i];
      end
    end
  end

  always_comb begin
    logic found;
    found     = 1'b0;
    first_idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (press[i] && !found) begin
        first_idx = SEL_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef PRESS_DECAY_EN
    logic any_full;
    any_full = 1'b0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      if (press[i] && counts[i] == CMAX) any_full = 1'b1;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      nxt[i] = any_full ? (counts[i] >> 1) : counts[i];
      if (press[i]) nxt[i] = nxt[i] + COUNT_WIDTH'(1);
    end
`else
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      nxt[i] = counts[i];
      if (press[i] && counts[i] != CMAX) nxt[i] = counts[i] + COUNT_WIDTH'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counts    <= '{default: '0};
      streak    <= '0;
      predicted <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      hit       <= 1'b0;
      miss      <= 1'b0;
      predicted <= best_idx;
      case (state)
        IDLE: if (mode_event) state <= CLEAR;
        CLEAR: begin
          counts    <= '{default: '0};
          streak    <= '0;
          predicted <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (mode_event) state <= HOLD;
          if (|press) begin
            counts <= nxt;
            if (first_idx == predicted) begin
              hit <= 1'b1;
              if (streak != STW'(IND_WIDTH)) streak <= streak + STW'(1);
            end else begin
              miss   <= 1'b1;
              streak <= '0;
            end
          end
        end
        HOLD: if (mode_event) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign display = (int'(sel) < NUM_BUTTONS) ? counts[sel] : '0;

  always_comb begin
    indicator = '0;
    for (int i = 0; i < IND_WIDTH; i++) indicator[i] = (streak > STW'(i));
  end

endmodule

// File: tb/tb_multi_channel_press_predictor.sv
// Randomised scoreboard bench for multi_channel_press_predictor against an arithmetic reference model.
module tb_multi_channel_press_predictor;

  localparam int NB   = 3;
  localparam int CW   = 4;
  localparam int IW   = 4;
  localparam int DB   = 4;
  localparam int SW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          activator = 1'b0;
  logic [NB-1:0] buttons = '0;
  logic [SW-1:0] sel = '0;
  logic [CW-1:0] display;
  logic [IW-1:0] indicator;
  logic [SW-1:0] predicted;
  logic          hit, miss;

  multi_channel_press_predictor #(
    .NUM_BUTTONS(NB), .COUNT_WIDTH(CW), .IND_WIDTH(IW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .activator(activator), .buttons(buttons), .sel(sel),
    .display(display), .indicator(indicator), .predicted(predicted), .hit(hit), .miss(miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hit;
    int miss;
    int pred;
    int ind;
    int disp;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   mcnt[NB];
  int   mstreak = 0;
  int   mmode   = 0;  // 0 idle, 1 run, 2 hold
  int   cur_sel = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_pred();
    int best = 0;
    for (int i = 1; i < NB; i++) if (mcnt[i] > mcnt[best]) best = i;
    return best;
  endfunction

  function automatic int model_disp(input int s);
    if (s < NB) return mcnt[s];
    return 0;
  endfunction

  function automatic int therm(input int s);
    return (1 << s) - 1;
  endfunction

  always @(negedge clk) begin
    if (!rst && (hit || miss)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_score: hit=%0d miss=%0d expected no score", hit, miss);
      end else begin
        me = q.pop_front();
        check("score_hit", int'(hit), me.hit);
        check("score_miss", int'(miss), me.miss);
        check("score_predicted", int'(predicted), me.pred);
        check("score_indicator", int'(indicator), me.ind);
        check("score_display", int'(display), me.disp);
      end
    end
  end

  // One-cycle raw pulse; the scored response lands between the 3rd and 4th edge.
  task automatic press(input int mask);
    exp_t e;
    int   first;
    bit   pushed;
    pushed = 1'b0;
    if (mmode == 1) begin
      first = 0;
      while (!mask[first]) first++;
      e.pred = model_pred();
      e.hit  = (first == e.pred) ? 1 : 0;
      e.miss = 1 - e.hit;
`ifdef PRESS_DECAY_EN
      begin
        bit full = 1'b0;
        for (int i = 0; i < NB; i++) if (mask[i] && mcnt[i] == CMAX) full = 1'b1;
        if (full) for (int i = 0; i < NB; i++) mcnt[i] = mcnt[i] / 2;
        for (int i = 0; i < NB; i++) if (mask[i]) mcnt[i]++;
      end
`else
      for (int i = 0; i < NB; i++) if (mask[i] && mcnt[i] < CMAX) mcnt[i]++;
`endif
      if (e.hit == 1) mstreak = (mstreak < IW) ? mstreak + 1 : IW;
      else mstreak = 0;
      e.ind  = therm(mstreak);
      e.disp = model_disp(cur_sel);
      q.push_back(e);
      pushed = 1'b1;
    end
    buttons = mask[NB-1:0];
    @(posedge clk);
    #1 buttons = '0;
    repeat (3) @(posedge clk);
    #1;
    if (pushed) check("score_arrived", q.size(), 0);
    q.delete();
  endtask

  task automatic activate(input int n);
    activator = 1'b1;
    repeat (n) @(posedge clk);
    #1 activator = 1'b0;
    if (n >= DB) begin
      case (mmode)
        0: begin
          for (int i = 0; i < NB; i++) mcnt[i] = 0;
          mstreak = 0;
          mmode   = 1;
        end
        1: mmode = 2;
        default: mmode = 1;
      endcase
    end
    repeat (14) @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    for (int s = 0; s < 4; s++) begin
      sel = s[SW-1:0];
      #1 check("display", int'(display), model_disp(s));
    end
    sel = cur_sel[SW-1:0];
    check("predicted", int'(predicted), model_pred());
    check("indicator", int'(indicator), therm(mstreak));
    check("idle_hit", int'(hit), 0);
    check("idle_miss", int'(miss), 0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < NB; i++) mcnt[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_display", int'(display), 0);
    check("rst_indicator", int'(indicator), 0);
    check("rst_predicted", int'(predicted), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_miss", int'(miss), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    press(2);
    check_all();
    activate(3);
    press(1);
    check_all();
    activate(6);
    check_all();

    cur_sel = 1;
    sel = 2'd1;
    press(2);
    press(2);
    press(1);
    check("dir_b1_count", int'(display), 2);
    check("dir_predicted_b1", int'(predicted), 1);
    press(5);
    check("dir_multi_indicator", int'(indicator), 0);
    check_all();
    repeat (14) press(2);
`ifdef PRESS_DECAY_EN
    check("dir_decay_b1", int'(display), 8);
`else
    check("dir_sat_b1", int'(display), 15);
`endif
    check_all();

    activate(6);
    repeat (3) press(4);
    check_all();
    activate(6);
    check_all();

    repeat (40) begin
      cur_sel = $urandom_range(0, 3);
      sel = cur_sel[SW-1:0];
      press($urandom_range(1, 7));
    end
    check_all();

    s = model_pred();
    cur_sel = s;
    sel = s[SW-1:0];
    buttons = 3'b010;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_display", int'(display), 0);
    check("midrst_indicator", int'(indicator), 0);
    check("midrst_predicted", int'(predicted), 0);
    check("midrst_hit", int'(hit), 0);
    check("midrst_miss", int'(miss), 0);
    for (int i = 0; i < NB; i++) mcnt[i] = 0;
    mstreak = 0;
    mmode   = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    activate(6);
    check_all();
    buttons = '0;
    repeat (4) @(posedge clk);
    #1;
    press(4);
    check_all();

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
